// File: rtl/img_feeder_if.sv
// img_feeder_if: valid/ready byte stream carrying packed 1-bit pixels into img_feeder.
interface img_feeder_if #(parameter int BYTE_W = 8);
    logic [BYTE_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    modport master (output s_data, s_valid, input s_ready);
    modport slave  (input s_data, s_valid, output s_ready);
endinterface

// File: rtl/img_feeder.sv
// img_feeder: serialises packed pixel words into img_proc as income/video/op,
// optionally preceded by a clear pass over the whole image.
module img_feeder #(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 128,
    parameter int BYTE_W     = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        skip_clear,
    input  logic [2:0]  op_sel,
    img_feeder_if.slave s,
    output logic        video,
    output logic        income,
    output logic [2:0]  op,
    output logic        busy,
    output logic        done
);
    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int PW   = $clog2(NPIX + 1);
    localparam int BW   = $clog2(BYTE_W + 1);
    localparam logic [2:0] S_RESET = 3'b000;
    localparam logic [2:0] S_READ  = 3'b110;
    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_t;
    state_t            state_q, state_d;
    logic [PW-1:0]     pix_q, pix_d;
    logic [BW-1:0]     left_q, left_d;
    logic [BYTE_W-1:0] sreg_q, sreg_d;
    logic [2:0]        op_q, op_d, lat_q, lat_d;
    logic              video_q, video_d, income_q, income_d, busy_q, busy_d, done_q, done_d;
    logic              last;
    assign last      = pix_q == PW'(NPIX);
    // left_q counts bits still to emit, so the next word is taken while the last bit is on the wire
    assign s.s_ready = state_q == LOAD && left_q == '0 && !last;
    assign video     = video_q;
    assign income    = income_q;
    assign op        = op_q;
    assign busy      = busy_q;
    assign done      = done_q;
    always_comb begin
        state_d  = state_q;
        pix_d    = pix_q;
        left_d   = left_q;
        sreg_d   = sreg_q;
        lat_d    = lat_q;
        op_d     = op_q;
        busy_d   = busy_q;
        video_d  = 1'b0;
        income_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                op_d = S_READ;
                if (start) begin
                    lat_d   = op_sel;
                    busy_d  = 1'b1;
                    state_d = skip_clear ? LOAD : CLEAR;
                    op_d    = skip_clear ? op_sel : S_RESET;
                    video_d = !skip_clear;
                    pix_d   = skip_clear ? '0 : PW'(1);
                end
            end
            CLEAR: begin
                state_d = last ? LOAD : CLEAR;
                op_d    = last ? lat_q : S_RESET;
                video_d = !last;
                pix_d   = last ? '0 : pix_q + PW'(1);
            end
            LOAD: begin
                if (last) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    left_d  = '0;
                end else if (left_q != '0) begin
                    video_d  = 1'b1;
                    income_d = sreg_q[BYTE_W-1];
                    sreg_d   = {sreg_q[BYTE_W-2:0], 1'b0};
                    left_d   = left_q - BW'(1);
                    pix_d    = pix_q + PW'(1);
                end else if (s.s_valid) begin
                    video_d  = 1'b1;
                    income_d = s.s_data[BYTE_W-1];
                    sreg_d   = {s.s_data[BYTE_W-2:0], 1'b0};
                    left_d   = BW'(BYTE_W - 1);
                    pix_d    = pix_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                op_d    = S_READ;
                pix_d   = '0;
            end
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pix_q    <= '0;
            left_q   <= '0;
            sreg_q   <= '0;
            lat_q    <= S_READ;
            op_q     <= S_READ;
            video_q  <= 1'b0;
            income_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pix_q    <= pix_d;
            left_q   <= left_d;
            sreg_q   <= sreg_d;
            lat_q    <= lat_d;
            op_q     <= op_d;
            video_q  <= video_d;
            income_q <= income_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end
endmodule
